clint: RTL and testbench

Core-Local Interruptor for a single-hart RISC-V core. It holds the machine software-interrupt bit (msip), a free-running 64-bit mtime counter and a 64-bit mtimecmp compare register, all behind a simple memory-mapped bus. It drives level interrupt lines to the core's interrupt logic.

---
 rtl/clint_pkg.sv | 18 +
 rtl/clint_timer.sv | 67 ++++++
 rtl/clint.sv | 101 ++++++++++
 tb/tb_clint.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared constants for the core-local interruptor: register offsets
// relative to the CLINT base address and the mtime counting modes.
package clint_pkg;

    localparam logic [31:0] MSIP_OFF        = 32'h0000_0000;
    localparam logic [31:0] MTIMECMP_LO_OFF = 32'h0000_4000;
    localparam logic [31:0] MTIMECMP_HI_OFF = 32'h0000_4004;
    localparam logic [31:0] MTIME_LO_OFF    = 32'h0000_BFF8;
    localparam logic [31:0] MTIME_HI_OFF    = 32'h0000_BFFC;

    typedef enum logic [1:0] {
        TM_STOP     = 2'b00,  // mtime and prescaler hold
        TM_EVERY    = 2'b01,  // one tick per clock
        TM_PRESCALE = 2'b10,  // one tick per PRESCALE clocks
        TM_STOP_ALT = 2'b11   // reserved encoding, behaves as stopped
    } timer_mode_e;

endpackage

// File: rtl/clint_timer.sv
// Free-running 64-bit mtime counter with an optional prescaler.
// A bus write to either half overrides the tick for that cycle: the written
// half takes the new value and the other half keeps its current value.
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] mtime_o
);

    localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    timer_mode_e   mode;
    logic          tick;
    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;

    assign mode    = timer_mode_e'(mode_i);
    assign mtime_o = mtime_q;

    // Next-state: prescaler advance, tick generation, write override.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        case (mode)
            TM_EVERY: tick = 1'b1;
            TM_PRESCALE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick    = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: ;
        endcase

        mtime_d = mtime_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) mtime_d[31:0]  = wdata_i;
            if (wr_hi_i) mtime_d[63:32] = wdata_i;
        end else if (tick) begin
            // Full 64-bit add: the low-to-high carry lands in the same cycle.
            mtime_d = mtime_q + 64'd1;
        end
    end

    // Counter and prescaler state.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            mtime_q <= '0;
        end else begin
            presc_q <= presc_d;
            mtime_q <= mtime_d;
        end
    end

endmodule

// File: rtl/clint.sv
// Core-local interruptor for a single hart: msip, mtime and mtimecmp behind
// a simple request/ready bus, driving level timer and software interrupts.
//
// Bus handshake: the requester raises bus_en with bus_we/bus_addr/bus_wdata
// and holds them until bus_ready. bus_ready is bus_en delayed by one clock.
// A write commits on every edge with bus_en & bus_we; read data is captured
// on every edge with bus_en & ~bus_we and is valid while bus_ready is high.
module clint
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_en,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ready,
    output logic        timer_irq_o,
    output logic        software_irq_o,
    input  logic        irq_enable,
    input  logic [1:0]  timer_mode
);

    localparam logic [31:0] MSIP_ADDR        = BASE_ADDR + MSIP_OFF;
    localparam logic [31:0] MTIMECMP_LO_ADDR = BASE_ADDR + MTIMECMP_LO_OFF;
    localparam logic [31:0] MTIMECMP_HI_ADDR = BASE_ADDR + MTIMECMP_HI_OFF;
    localparam logic [31:0] MTIME_LO_ADDR    = BASE_ADDR + MTIME_LO_OFF;
    localparam logic [31:0] MTIME_HI_ADDR    = BASE_ADDR + MTIME_HI_OFF;

    logic        msip_q;
    logic [63:0] mtimecmp_q;
    logic [63:0] mtime;
    logic        bus_ready_q;
    logic [31:0] bus_rdata_q, bus_rdata_d;

    logic hit_msip, hit_cmp_lo, hit_cmp_hi, hit_mtime_lo, hit_mtime_hi;
    logic wr_en, rd_en;
    logic unused_addr_bits;

    // Registers are word-aligned; the byte offset within a word is ignored.
    assign unused_addr_bits = ^bus_addr[1:0];

    assign hit_msip     = (bus_addr[31:2] == MSIP_ADDR[31:2]);
    assign hit_cmp_lo   = (bus_addr[31:2] == MTIMECMP_LO_ADDR[31:2]);
    assign hit_cmp_hi   = (bus_addr[31:2] == MTIMECMP_HI_ADDR[31:2]);
    assign hit_mtime_lo = (bus_addr[31:2] == MTIME_LO_ADDR[31:2]);
    assign hit_mtime_hi = (bus_addr[31:2] == MTIME_HI_ADDR[31:2]);

    assign wr_en = bus_en & bus_we;
    assign rd_en = bus_en & ~bus_we;

    clint_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .mode_i  (timer_mode),
        .wr_lo_i (wr_en & hit_mtime_lo),
        .wr_hi_i (wr_en & hit_mtime_hi),
        .wdata_i (bus_wdata),
        .mtime_o (mtime)
    );

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        bus_rdata_d = '0;
        if (hit_msip)          bus_rdata_d = {31'd0, msip_q};
        else if (hit_cmp_lo)   bus_rdata_d = mtimecmp_q[31:0];
        else if (hit_cmp_hi)   bus_rdata_d = mtimecmp_q[63:32];
        else if (hit_mtime_lo) bus_rdata_d = mtime[31:0];
        else if (hit_mtime_hi) bus_rdata_d = mtime[63:32];
    end

    // Bus response registers, msip and mtimecmp.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ready_q <= 1'b0;
            bus_rdata_q <= '0;
            msip_q      <= 1'b0;
            mtimecmp_q  <= '1;
        end else begin
            bus_ready_q <= bus_en;
            if (rd_en) bus_rdata_q <= bus_rdata_d;
            if (wr_en && hit_msip)   msip_q             <= bus_wdata[0];
            if (wr_en && hit_cmp_lo) mtimecmp_q[31:0]   <= bus_wdata;
            if (wr_en && hit_cmp_hi) mtimecmp_q[63:32]  <= bus_wdata;
        end
    end

    assign bus_ready = bus_ready_q;
    assign bus_rdata = bus_rdata_q;

    // Level interrupts straight from register state, gated globally.
    assign timer_irq_o    = irq_enable & (mtime >= mtimecmp_q);
    assign software_irq_o = irq_enable & msip_q;

endmodule

// File: tb/tb_clint.sv
// Bench for the core-local interruptor: bus driver tasks, a reference model
// of the register file and mtime, and a queue of expected read data.
module tb_clint;

    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam int unsigned PRESCALE = 16;
    localparam logic [31:0] A_MSIP   = BASE + 32'h0000;
    localparam logic [31:0] A_CMP_LO = BASE + 32'h4000;
    localparam logic [31:0] A_CMP_HI = BASE + 32'h4004;
    localparam logic [31:0] A_MT_LO  = BASE + 32'hBFF8;
    localparam logic [31:0] A_MT_HI  = BASE + 32'hBFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_en, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;
    logic        timer_irq_o, software_irq_o;
    logic        irq_enable;
    logic [1:0]  timer_mode;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    clint #(
        .BASE_ADDR (BASE),
        .PRESCALE  (PRESCALE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_en         (bus_en),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_ready      (bus_ready),
        .timer_irq_o    (timer_irq_o),
        .software_irq_o (software_irq_o),
        .irq_enable     (irq_enable),
        .timer_mode     (timer_mode)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        m_msip;
    logic [63:0] m_cmp;
    logic [63:0] m_mtime;
    int unsigned m_presc;
    logic        m_tick;
    logic [31:0] m_wa;

    always @(posedge clk) begin
        m_wa = {bus_addr[31:2], 2'b00};
        if (rst) begin
            m_msip  = 1'b0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_mtime = 64'd0;
            m_presc = 0;
        end else begin
            m_tick = (timer_mode == 2'b01) ||
                     (timer_mode == 2'b10 && m_presc == PRESCALE - 1);
            if (timer_mode == 2'b10)
                m_presc = (m_presc == PRESCALE - 1) ? 0 : m_presc + 1;
            if (bus_en && bus_we && m_wa == A_MSIP)   m_msip        = bus_wdata[0];
            if (bus_en && bus_we && m_wa == A_CMP_LO) m_cmp[31:0]   = bus_wdata;
            if (bus_en && bus_we && m_wa == A_CMP_HI) m_cmp[63:32]  = bus_wdata;
            if (bus_en && bus_we && m_wa == A_MT_LO)      m_mtime[31:0]  = bus_wdata;
            else if (bus_en && bus_we && m_wa == A_MT_HI) m_mtime[63:32] = bus_wdata;
            else if (m_tick)                              m_mtime        = m_mtime + 64'd1;
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (wa == A_MSIP)   return {31'd0, m_msip};
        if (wa == A_CMP_LO) return m_cmp[31:0];
        if (wa == A_CMP_HI) return m_cmp[63:32];
        if (wa == A_MT_LO)  return m_mtime[31:0];
        if (wa == A_MT_HI)  return m_mtime[63:32];
        return 32'd0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        int cyc;
        bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!bus_ready && cyc < 20);
        n_vec++;
        if (bus_ready !== 1'b1) begin
            n_err++;
            $display("FAIL write_ready addr=%h: bus_ready=%b expected 1", a, bus_ready);
        end
        bus_en = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        int cyc;
        logic [31:0] e;
        exp_q.push_back(exp);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!bus_ready && cyc < 20);
        e = exp_q.pop_front();
        n_vec++;
        if (bus_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s: bus_ready timeout, expected data %h", name, e);
        end else if (bus_rdata !== e) begin
            n_err++;
            $display("FAIL %s: rdata=%h expected %h", name, bus_rdata, e);
        end
        bus_en = 1'b0;
    endtask

    task automatic check_irqs(input logic t_exp, input logic s_exp, input string name);
        n_vec++;
        if (timer_irq_o !== t_exp || software_irq_o !== s_exp) begin
            n_err++;
            $display("FAIL %s: timer_irq=%b sw_irq=%b expected %b %b",
                     name, timer_irq_o, software_irq_o, t_exp, s_exp);
        end
    endtask

    task automatic apply_reset(input logic [1:0] mode);
        rst = 1'b1; timer_mode = mode;
        bus_en = 1'b0; bus_we = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        apply_reset(2'b00);
        n_vec++;
        if (bus_ready !== 1'b0 || bus_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_bus: ready=%b rdata=%h expected 0 0", bus_ready, bus_rdata);
        end
        check_irqs(1'b0, 1'b0, "reset_irqs");
        bus_read(A_MSIP,   32'd0,          "reset_msip");
        bus_read(A_CMP_LO, 32'hFFFF_FFFF,  "reset_cmp_lo");
        bus_read(A_CMP_HI, 32'hFFFF_FFFF,  "reset_cmp_hi");
        bus_read(A_MT_LO,  32'd0,          "reset_mtime_lo");
        bus_read(A_MT_HI,  32'd0,          "reset_mtime_hi");
    endtask

    task automatic test_msip;
        bus_write(A_MSIP, 32'h1);
        check_irqs(1'b0, 1'b1, "msip_set_irq");
        bus_read(A_MSIP, 32'h1, "msip_set_read");
        bus_write(A_MSIP, 32'h0);
        check_irqs(1'b0, 1'b0, "msip_clr_irq");
        bus_write(A_MSIP, 32'hFFFF_FFFE);
        bus_read(A_MSIP, 32'h0, "msip_upper_bits");
        check_irqs(1'b0, 1'b0, "msip_upper_irq");
    endtask

    task automatic test_timer_every;
        bus_write(A_CMP_LO, 32'h20);
        bus_write(A_CMP_HI, 32'h0);
        timer_mode = 2'b01;
        step(50);
        check_irqs(1'b1, 1'b0, "mode01_timer_irq");
        bus_read(A_MT_LO, model_read(A_MT_LO), "mode01_mtime_lo");
        bus_read(A_MT_HI, 32'd0, "mode01_mtime_hi");
        bus_write(A_MSIP, 32'h1);
        irq_enable = 1'b0;
        step(1);
        check_irqs(1'b0, 1'b0, "irq_gate_off");
        irq_enable = 1'b1;
        step(1);
        check_irqs(1'b1, 1'b1, "irq_gate_on");
        bus_write(A_MSIP, 32'h0);
    endtask

    task automatic test_prescale;
        logic [31:0] held;
        apply_reset(2'b10);
        step(160);
        bus_read(A_MT_LO, 32'd10, "mode10_mtime_lo");
        timer_mode = 2'b00;
        held = model_read(A_MT_LO);
        bus_read(A_MT_LO, held, "mode00_before");
        step(100);
        bus_read(A_MT_LO, held, "mode00_after");
        timer_mode = 2'b11;
        step(40);
        bus_read(A_MT_LO, held, "mode11_hold");
    endtask

    task automatic test_carry_and_override;
        timer_mode = 2'b01;
        bus_write(A_MT_HI, 32'h0);
        bus_write(A_MT_LO, 32'hFFFF_FFFF);
        bus_read(A_MT_LO, 32'hFFFF_FFFF, "override_lo_exact");
        step(2);
        bus_read(A_MT_HI, 32'h1, "carry_into_hi");
        bus_write(A_MT_LO, 32'h0000_1234);
        bus_read(A_MT_LO, 32'h0000_1234, "override_while_tick");
        // 64-bit wrap to zero
        timer_mode = 2'b00;
        bus_write(A_MT_HI, 32'hFFFF_FFFF);
        bus_write(A_MT_LO, 32'hFFFF_FFFF);
        timer_mode = 2'b01;
        step(1);
        timer_mode = 2'b00;
        bus_read(A_MT_LO, 32'd0, "wrap_lo");
        bus_read(A_MT_HI, 32'd0, "wrap_hi");
    endtask

    task automatic test_compare_boundary;
        timer_mode = 2'b00;
        bus_write(A_CMP_HI, 32'hFFFF_FFFF);
        bus_write(A_MT_HI, 32'h0);
        bus_write(A_MT_LO, 32'h100);
        check_irqs(1'b0, 1'b0, "cmp_hi_raised");
        bus_write(A_CMP_LO, 32'h100);
        bus_write(A_CMP_HI, 32'h0);
        check_irqs(1'b1, 1'b0, "cmp_equal");
        bus_write(A_CMP_LO, 32'h101);
        check_irqs(1'b0, 1'b0, "cmp_one_above");
        bus_write(A_MT_LO, 32'h101);
        check_irqs(1'b1, 1'b0, "mtime_rewrite_equal");
        bus_write(A_CMP_HI, 32'h1);
        check_irqs(1'b0, 1'b0, "cmp_hi_above");
    endtask

    task automatic test_unmapped;
        bus_read(BASE + 32'h1000, 32'd0, "unmapped_read");
        step(1);
        n_vec++;
        if (bus_ready !== 1'b0) begin
            n_err++;
            $display("FAIL unmapped_ready_drop: bus_ready=%b expected 0", bus_ready);
        end
        bus_write(BASE + 32'h1000, 32'h1);
        bus_write(32'h0300_0000, 32'h1);
        bus_read(A_MSIP, 32'd0, "unmapped_write_ignored");
        bus_read(A_MSIP + 32'h3, 32'd0, "byte_offset_alias");
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        timer_mode = 2'b00;
        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            bus_write(A_CMP_LO, d);
            bus_read(A_CMP_LO, d, "b2b_cmp_lo");
            d = $urandom_range(0, 3);
            bus_write(A_MSIP, d);
            bus_read(A_MSIP, model_read(A_MSIP), "b2b_msip");
        end
        bus_write(A_CMP_HI, 32'hA5A5_0001);
        bus_write(A_CMP_HI, 32'hA5A5_0001);
        bus_read(A_CMP_HI, 32'hA5A5_0001, "idempotent_write");
    endtask

    task automatic test_reset_mid_access;
        bus_write(A_MSIP, 32'h1);
        bus_write(A_CMP_LO, 32'h55);
        bus_en = 1'b1; bus_we = 1'b0; bus_addr = A_CMP_LO;
        rst = 1'b1;
        step(1);
        n_vec++;
        if (bus_ready !== 1'b0 || bus_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_mid_access: ready=%b rdata=%h expected 0 0", bus_ready, bus_rdata);
        end
        bus_en = 1'b0;
        rst = 1'b0;
        timer_mode = 2'b00;
        step(1);
        check_irqs(1'b0, 1'b0, "reset_mid_irqs");
        bus_read(A_MSIP,   32'd0,         "rst2_msip");
        bus_read(A_CMP_LO, 32'hFFFF_FFFF, "rst2_cmp_lo");
        bus_read(A_CMP_HI, 32'hFFFF_FFFF, "rst2_cmp_hi");
        bus_read(A_MT_LO,  32'd0,         "rst2_mtime_lo");
        bus_read(A_MT_HI,  32'd0,         "rst2_mtime_hi");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1; bus_en = 1'b0; bus_we = 1'b0;
        bus_addr = '0; bus_wdata = '0;
        irq_enable = 1'b1; timer_mode = 2'b00;
        step(1);
        test_reset;
        test_msip;
        test_timer_every;
        test_prescale;
        test_carry_and_override;
        test_compare_boundary;
        test_unmapped;
        test_back_to_back;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
